// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
//   Detects load-use hazards between EX and ID, sequences multi-cycle
//   multiply/divide stalls, and flushes IF/ID on taken branches.
// Ports:
//   clk, rst (sync, active-low)
//   ID_RegRs, ID_RegRt, ID_UseRt, ID_MulDiv          : ID-stage instruction info
//   EX_MemRead, EX_RegRd, EX_BranchTaken             : EX-stage instruction info
//   PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble    : pipeline control (combinational)
//   MD_Start                                         : one-cycle mul/div start pulse
//   State                                            : RUN=00 LDSTALL=01 MDWAIT=10 FLUSH=11
//   STALL_Cnt, FLUSH_Cnt                             : saturating event counters
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_RegRs,
  input  logic [4:0]  ID_RegRt,
  input  logic        ID_UseRt,
  input  logic        ID_MulDiv,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_RegRd,
  input  logic        EX_BranchTaken,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        MD_Start,
  output logic [1:0]  State,
  output logic [15:0] STALL_Cnt,
  output logic [15:0] FLUSH_Cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MDWAIT  = 2'b10,
    FLUSH   = 2'b11
  } state_e;

  // Issue cycle is the first stall cycle, so the wait counter covers the rest.
  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        load_use;

  // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use = EX_MemRead && (EX_RegRd != 5'd0) &&
                    ((EX_RegRd == ID_RegRs) || (ID_UseRt && (EX_RegRd == ID_RegRt)));

  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    MD_Start    = 1'b0;
    state_d     = RUN;
    md_cnt_d    = '0;

    if (rst) begin
      if (state_q == MDWAIT) begin
        if (EX_BranchTaken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          state_d     = FLUSH;
        end else if (md_cnt_q != '0) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          md_cnt_d    = md_cnt_q - 4'd1;
          state_d     = MDWAIT;
        end
      end else begin
        if (EX_BranchTaken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          state_d     = FLUSH;
        end else if (load_use) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          state_d     = LDSTALL;
        end else if (ID_MulDiv) begin
          MD_Start    = 1'b1;
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          md_cnt_d    = MD_LOAD;
          state_d     = MDWAIT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      if (!PC_Write && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (IFID_Flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign State     = state_q;
  assign STALL_Cnt = stall_cnt_q;
  assign FLUSH_Cnt = flush_cnt_q;

endmodule
